// File: rtl/bmd_256_latency_drain_ctrl.sv
// Drains latched timestamps from the latency FIFO to the TX engine in bursts of up to BURST_LEN beats.
// Optional macro BMD_DRAIN_DELTA_EN sends timestamp deltas instead of raw values.
module bmd_256_latency_drain_ctrl #(
    parameter int TS_W      = 30,
    parameter int BURST_LEN = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            latency_reset_signal,
    input  logic            fifo_read_trigger,
    input  logic            fifo_counter_empty,
    input  logic [TS_W-1:0] fifo_counter_value,
    output logic            fifo_counter_read_en,
    output logic            tx_req,
    input  logic            tx_gnt,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [TS_W-1:0] tx_data,
    output logic            tx_last,
    output logic            drain_busy,
    output logic [12:0]     drain_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_POP,
        S_LATCH,
        S_SEND
    } state_t;

    localparam logic [7:0]  LP_LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [12:0] LP_CNT_MAX   = 13'h1FFF;

    state_t          r_state;
    logic            r_tx_req;
    logic            r_tx_valid;
    logic            r_tx_last;
    logic [TS_W-1:0] r_tx_data;
    logic [7:0]      r_beat_cnt;
    logic [12:0]     r_drain_count;

    logic            w_hs;
    logic [TS_W-1:0] w_latch_data;

    assign w_hs = r_tx_valid & tx_ready;

`ifdef BMD_DRAIN_DELTA_EN
    logic [TS_W-1:0] r_cur_ts;
    logic [TS_W-1:0] r_prev_ts;
    logic            r_prev_vld;

    // Subtraction wraps naturally modulo 2^TS_W; first beat after a clear is sent raw.
    assign w_latch_data = r_prev_vld ? (fifo_counter_value - r_prev_ts) : fifo_counter_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_ts   <= '0;
            r_prev_ts  <= '0;
            r_prev_vld <= 1'b0;
        end else if (latency_reset_signal) begin
            r_cur_ts   <= '0;
            r_prev_ts  <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            if (r_state == S_LATCH) begin
                r_cur_ts <= fifo_counter_value;
            end
            if (w_hs) begin
                r_prev_ts  <= r_cur_ts;
                r_prev_vld <= 1'b1;
            end
        end
    end
`else
    assign w_latch_data = fifo_counter_value;
`endif

    // Pop strobe is decoded from the state so it can be suppressed in the same cycle as a clear.
    assign fifo_counter_read_en = (r_state == S_POP) & ~fifo_counter_empty & ~latency_reset_signal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tx_req      <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_last     <= 1'b0;
            r_tx_data     <= '0;
            r_beat_cnt    <= '0;
            r_drain_count <= '0;
        end else if (latency_reset_signal) begin
            r_state       <= S_IDLE;
            r_tx_req      <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_last     <= 1'b0;
            r_tx_data     <= '0;
            r_beat_cnt    <= '0;
            r_drain_count <= '0;
        end else begin
            if (w_hs && (r_drain_count != LP_CNT_MAX)) begin
                r_drain_count <= r_drain_count + 13'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (fifo_read_trigger && !fifo_counter_empty) begin
                        r_state  <= S_REQ;
                        r_tx_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    // After a re-arbitration tx_req is low for the first REQ cycle.
                    if (!r_tx_req) begin
                        r_tx_req <= 1'b1;
                    end else if (tx_gnt) begin
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_tx_data  <= w_latch_data;
                    r_tx_last  <= (r_beat_cnt == LP_LAST_BEAT) | fifo_counter_empty;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                        if (r_tx_last) begin
                            r_beat_cnt <= '0;
                            r_tx_req   <= 1'b0;
                            if (!fifo_counter_empty && fifo_read_trigger) begin
                                r_state <= S_REQ;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                            r_state    <= S_POP;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_req      = r_tx_req;
    assign tx_valid    = r_tx_valid;
    assign tx_last     = r_tx_last;
    assign tx_data     = r_tx_data;
    assign drain_busy  = (r_state != S_IDLE);
    assign drain_count = r_drain_count;

endmodule

// File: tb/tb_bmd_256_latency_drain_ctrl.sv
// Scoreboard bench for bmd_256_latency_drain_ctrl; expectations follow BMD_DRAIN_DELTA_EN when defined.
module tb_bmd_256_latency_drain_ctrl;

    localparam int TS_W      = 30;
    localparam int BURST_LEN = 8;
`ifdef BMD_DRAIN_DELTA_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif

    typedef struct {
        logic [TS_W-1:0] data;
        logic            last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            latency_reset_signal = 1'b0;
    logic            fifo_read_trigger = 1'b0;
    logic            fifo_counter_empty;
    logic [TS_W-1:0] fifo_counter_value = '0;
    logic            fifo_counter_read_en;
    logic            tx_req;
    logic            tx_gnt = 1'b1;
    logic            tx_valid;
    logic            tx_ready = 1'b1;
    logic [TS_W-1:0] tx_data;
    logic            tx_last;
    logic            drain_busy;
    logic [12:0]     drain_count;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t exp_q[$];
    logic [TS_W-1:0] fifo_mem [0:16383];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int last_cnt = 0;
    int beats_in_burst = 0;

    always #2 clk = ~clk;

    bmd_256_latency_drain_ctrl #(.TS_W(TS_W), .BURST_LEN(BURST_LEN)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .latency_reset_signal (latency_reset_signal),
        .fifo_read_trigger    (fifo_read_trigger),
        .fifo_counter_empty   (fifo_counter_empty),
        .fifo_counter_value   (fifo_counter_value),
        .fifo_counter_read_en (fifo_counter_read_en),
        .tx_req               (tx_req),
        .tx_gnt               (tx_gnt),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .tx_data              (tx_data),
        .tx_last              (tx_last),
        .drain_busy           (drain_busy),
        .drain_count          (drain_count)
    );

    // FIFO model: dout valid the cycle after a read enable.
    assign fifo_counter_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_counter_read_en) begin
            if (rd_ptr != wr_ptr) begin
                fifo_counter_value <= fifo_mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the expected beat on every handshake seen between edges.
    always @(negedge clk) begin
        if (latency_reset_signal) begin
            beats_in_burst = 0;
        end else if (rst_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", 32'(tx_data), 32'(e.data));
                check("beat_last", 32'(tx_last), 32'(e.last));
            end
            beats_in_burst++;
            if (tx_last) begin
                last_cnt++;
                check("burst_len_max", 32'(beats_in_burst <= BURST_LEN), 32'd1);
                beats_in_burst = 0;
            end
        end
    end

    task automatic push_fifo(input logic [TS_W-1:0] v);
        fifo_mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic exp_push(input logic [TS_W-1:0] d, input logic l);
        beat_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        latency_reset_signal = 1'b1;
        tick();
        latency_reset_signal = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit seen = 0;
        bit done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            tick();
            if (drain_busy) seen = 1;
            else if (seen) done = 1;
        end
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !tx_valid; i++) tick();
        if (!tx_valid) check({name, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int pops0, last0;
        logic [TS_W-1:0] hold_data;
        logic            hold_last;
        logic [TS_W-1:0] v;

        // Reset state
        repeat (3) tick();
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(drain_busy), 32'd0);
        check("rst_drain_count", 32'(drain_count), 32'd0);
        check("rst_read_en", 32'(fifo_counter_read_en), 32'd0);
        rst_n = 1'b1;
        tick();

        // 20 entries: bursts of 8, 8, 4
        clear_pulse();
        pops0 = pop_cnt;
        last0 = last_cnt;
        for (int i = 0; i < 20; i++) begin
            v = TS_W'(1000 + i);
            push_fifo(v);
            exp_push(DELTA && i != 0 ? TS_W'(1) : v, (i == 7) || (i == 15) || (i == 19));
        end
        fifo_read_trigger = 1'b1;
        wait_done("burst20", 400);
        fifo_read_trigger = 1'b0;
        check("burst20_drain_count", 32'(drain_count), 32'd20);
        check("burst20_lasts", 32'(last_cnt - last0), 32'd3);
        check("burst20_pops", 32'(pop_cnt - pops0), 32'd20);
        check("burst20_idle", 32'(drain_busy), 32'd0);
        check("burst20_tx_req", 32'(tx_req), 32'd0);

        // tx_ready stall in SEND
        clear_pulse();
        tx_ready = 1'b0;
        push_fifo(TS_W'(500));
        push_fifo(TS_W'(600));
        exp_push(TS_W'(500), 1'b0);
        exp_push(DELTA ? TS_W'(100) : TS_W'(600), 1'b1);
        pops0 = pop_cnt;
        fifo_read_trigger = 1'b1;
        tick();
        wait_valid("stall");
        hold_data = tx_data;
        hold_last = tx_last;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_data", 32'(tx_data), 32'(hold_data));
            check("stall_last", 32'(tx_last), 32'(hold_last));
            check("stall_pops", 32'(pop_cnt - pops0), 32'd1);
            check("stall_drain_count", 32'(drain_count), 32'd0);
        end
        tx_ready = 1'b1;
        wait_done("stall", 100);
        fifo_read_trigger = 1'b0;
        check("stall_end_drain_count", 32'(drain_count), 32'd2);

        // Clear during beat 3 aborts the burst
        clear_pulse();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_fifo(TS_W'(10 + i));
        exp_push(TS_W'(10), 1'b0);
        exp_push(DELTA ? TS_W'(1) : TS_W'(11), 1'b0);
        last0 = last_cnt;
        fifo_read_trigger = 1'b1;
        for (int b = 0; b < 2; b++) begin
            tick();
            wait_valid("abort");
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
        end
        wait_valid("abort3");
        fifo_read_trigger = 1'b0;
        clear_pulse();
        check("abort_busy", 32'(drain_busy), 32'd0);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_tx_req", 32'(tx_req), 32'd0);
        check("abort_tx_last", 32'(tx_last), 32'd0);
        check("abort_drain_count", 32'(drain_count), 32'd0);
        check("abort_no_last", 32'(last_cnt - last0), 32'd0);
        wr_ptr = rd_ptr;
        tx_ready = 1'b1;
        tick();

        // FIFO empties after 3 pops
        clear_pulse();
        pops0 = pop_cnt;
        push_fifo(TS_W'(7));
        push_fifo(TS_W'(8));
        push_fifo(TS_W'(9));
        exp_push(TS_W'(7), 1'b0);
        exp_push(DELTA ? TS_W'(1) : TS_W'(8), 1'b0);
        exp_push(DELTA ? TS_W'(1) : TS_W'(9), 1'b1);
        fifo_read_trigger = 1'b1;
        wait_done("empty3", 100);
        fifo_read_trigger = 1'b0;
        check("empty3_pops", 32'(pop_cnt - pops0), 32'd3);
        check("empty3_drain_count", 32'(drain_count), 32'd3);

        // Wrap-around timestamps
        clear_pulse();
        push_fifo(TS_W'(100));
        push_fifo(TS_W'(130));
        push_fifo(TS_W'(1073741823));
        push_fifo(TS_W'(5));
        exp_push(TS_W'(100), 1'b0);
        exp_push(DELTA ? TS_W'(30) : TS_W'(130), 1'b0);
        exp_push(DELTA ? TS_W'(1073741693) : TS_W'(1073741823), 1'b0);
        exp_push(DELTA ? TS_W'(6) : TS_W'(5), 1'b1);
        fifo_read_trigger = 1'b1;
        wait_done("wrap", 100);
        fifo_read_trigger = 1'b0;

        // drain_count saturation
        clear_pulse();
        for (int i = 0; i < 8200; i++) begin
            v = TS_W'(5 + 2 * i);
            push_fifo(v);
            exp_push(DELTA && i != 0 ? TS_W'(2) : v, (i % 8 == 7));
        end
        fifo_read_trigger = 1'b1;
        wait_done("sat", 60000);
        fifo_read_trigger = 1'b0;
        check("sat_drain_count", 32'(drain_count), 32'd8191);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
